// File: rtl/cmos_serial_adder.sv
// cmos_serial_adder: bit-serial WIDTH-bit adder closed around a single
// cmos_fullAdder cell. Operands load in parallel, bits are added LSB-first
// one per clock through the cell, and the sum is rebuilt in a shift register.
// Optional feature macro: CMOS_SERIAL_OVF_EN (signed overflow flag on ovf).

// cmos_fullAdder: mirror-adder full adder. Each output is produced as the
// inverted result of a complementary pull-up/pull-down network followed by
// an output inverter, the same stage structure as the transistor-level cell.
module cmos_fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic cout_n;
    logic sum_n;

    // First stage: inverted carry (majority) network.
    assign cout_n = ~((a & b) | (cin & (a | b)));
    // Second stage: inverted sum reuses the inverted carry.
    assign sum_n  = ~((a & b & cin) | (cout_n & (a | b | cin)));
    // Output inverters.
    assign cout   = ~cout_n;
    assign sum    = ~sum_n;
endmodule

module cmos_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             load;

    logic [WIDTH-1:0] ra_reg;
    logic [WIDTH-1:0] rb_reg;
    logic [WIDTH-1:0] rs_reg;
    logic             rc_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    // The one full-adder cell sees the current LSBs and the looped carry.
    cmos_fullAdder fa (
        .a    (ra_reg[0]),
        .b    (rb_reg[0]),
        .cin  (rc_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (state_reg == RUN) && (cnt_reg == LAST_BIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is honoured in IDLE and DONE, ignored in RUN.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Serial datapath: load operands, then shift one bit per RUN cycle.
    // The result registers change only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_reg   <= '0;
            rb_reg   <= '0;
            rs_reg   <= '0;
            rc_reg   <= 1'b0;
            cnt_reg  <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else if (load) begin
            ra_reg  <= a;
            rb_reg  <= b;
            rc_reg  <= cin;
            cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            ra_reg  <= {1'b0, ra_reg[WIDTH-1:1]};
            rb_reg  <= {1'b0, rb_reg[WIDTH-1:1]};
            rs_reg  <= {fa_sum, rs_reg[WIDTH-1:1]};
            rc_reg  <= fa_cout;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_bit) begin
                sum_reg  <= {fa_sum, rs_reg[WIDTH-1:1]};
                cout_reg <= fa_cout;
            end
        end
    end

`ifdef CMOS_SERIAL_OVF_EN
    logic ovf_reg;

    // On the MSB step rc holds the carry into the MSB; xor with its carry-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (last_bit) begin
            ovf_reg <= rc_reg ^ fa_cout;
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
endmodule
